// File: rtl/pwm_duty_generator.sv
// PWM generator fed by a duty byte from the I2C slave's SCK domain.
// The byte is resynchronised, qualified for stability and applied only at period wrap.
module pwm_duty_generator #(
  parameter int N = 31,
  parameter int K = 1
) (
  input  logic       CLK_IN,
  input  logic       RST_N,
  input  logic       EN,
  input  logic [7:0] PWM_DCycle,
  output logic       PWM_OUT,
  output logic       PERIOD_START,
  output logic [7:0] DUTY_ACTIVE
);

  localparam logic [15:0] PTC = 16'(N);

  logic [7:0]         s1_q, s2_q;
  logic [K-1:0][7:0]  hist_q, hist_d;
  logic [7:0]         pending_q, pending_d;
  logic [7:0]         duty_q, duty_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [15:0]        pcnt_q, pcnt_d;
  logic               pwm_q, pwm_d;
  logic               pstart_q, pstart_d;
  logic               stable, tick, wrap;

  // Qualifier: accept s2 only once it matches all K previous samples.
  always_comb begin
    stable    = 1'b1;
    hist_d    = hist_q;
    hist_d[0] = s2_q;
    for (int i = 1; i < K; i++) hist_d[i] = hist_q[i-1];
    for (int i = 0; i < K; i++)
      if (hist_q[i] != s2_q) stable = 1'b0;
    pending_d = stable ? s2_q : pending_q;
  end

  always_comb begin
    tick     = EN && (pcnt_q == PTC);
    wrap     = tick && (cnt_q == 8'hFF);
    pcnt_d   = 16'd0;
    cnt_d    = 8'd0;
    duty_d   = pending_q;
    if (EN) begin
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
      cnt_d  = tick ? cnt_q + 8'd1 : cnt_q;
      // Old pending is taken at wrap; a same-cycle update waits a full period.
      duty_d = wrap ? pending_q : duty_q;
    end
    pstart_d = wrap;
    pwm_d    = EN && (cnt_q < duty_q);
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      s1_q      <= '0;
      s2_q      <= '0;
      hist_q    <= '0;
      pending_q <= '0;
      duty_q    <= '0;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      pwm_q     <= 1'b0;
      pstart_q  <= 1'b0;
    end else begin
      s1_q      <= PWM_DCycle;
      s2_q      <= s1_q;
      hist_q    <= hist_d;
      pending_q <= pending_d;
      duty_q    <= duty_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      pwm_q     <= pwm_d;
      pstart_q  <= pstart_d;
    end
  end

  assign PWM_OUT      = pwm_q;
  assign PERIOD_START = pstart_q;
  assign DUTY_ACTIVE  = duty_q;

endmodule

// File: tb/tb_pwm_duty_generator.sv
// Directed bench for pwm_duty_generator with N=3, K=1 (1024-clock period).
module tb_pwm_duty_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] dcyc;
  logic       pwm;
  logic       pstart;
  logic [7:0] duty;

  int checks = 0;
  int fails  = 0;

  pwm_duty_generator #(.N(3), .K(1)) dut (
    .CLK_IN(clk), .RST_N(rst_n), .EN(en), .PWM_DCycle(dcyc),
    .PWM_OUT(pwm), .PERIOD_START(pstart), .DUTY_ACTIVE(duty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_pstart();
    int n = 0;
    while (!pstart && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!pstart) check("pstart_timeout", 32'(pstart), 32'd1);
  endtask

  // From one PERIOD_START sample to the next: high samples and period length.
  task automatic measure(output int hi, output int len);
    wait_pstart();
    hi = 0; len = 0;
    do begin
      hi += int'(pwm);
      len++;
      @(negedge clk);
    end while (!pstart && len < 3000);
  endtask

  task automatic load_duty(input logic [7:0] d, input string tag);
    en   = 1'b0;
    dcyc = d;
    repeat (6) @(negedge clk);
    check(tag, 32'(duty), 32'(d));
  endtask

  initial begin
    int hi, len;
    rst_n = 1'b0; en = 1'b1; dcyc = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_pwm",    32'(pwm),    32'd0);
    check("rst_pstart", 32'(pstart), 32'd0);
    check("rst_duty",   32'(duty),   32'd0);

    // Release with EN low so the byte loads while idle.
    en = 1'b0; rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("load_lat4", 32'(duty), 32'd0);
    @(negedge clk);
    check("load_lat5", 32'(duty), 32'hFF);

    // Steady duty 64.
    load_duty(8'd64, "load64");
    en = 1'b1;
    measure(hi, len);
    check("d64_hi",  32'(hi),  32'd256);
    check("d64_len", 32'(len), 32'd1024);

    // Duty 0.
    load_duty(8'd0, "load0");
    en = 1'b1;
    measure(hi, len);
    check("d0_hi",  32'(hi),  32'd0);
    check("d0_len", 32'(len), 32'd1024);

    // Duty 255.
    load_duty(8'd255, "load255");
    en = 1'b1;
    measure(hi, len);
    check("d255_lo",  32'(len - hi), 32'd4);
    check("d255_len", 32'(len),      32'd1024);

    // Deferred update 64 -> 192 at cnt=100.
    load_duty(8'd64, "load64b");
    en = 1'b1;
    wait_pstart();
    hi = 0; len = 0;
    do begin
      hi += int'(pwm);
      len++;
      if (len == 400) dcyc = 8'd192;
      if (len == 1000) check("defer_mid_duty", 32'(duty), 32'd64);
      @(negedge clk);
    end while (!pstart && len < 3000);
    check("defer_cur_hi",  32'(hi),   32'd256);
    check("defer_len",     32'(len),  32'd1024);
    check("defer_new_duty", 32'(duty), 32'd192);
    measure(hi, len);
    check("defer_next_hi", 32'(hi), 32'd768);

    // Glitch rejection, observed through the idle-tracking duty register.
    load_duty(8'h80, "load80");
    dcyc = 8'h55;
    @(negedge clk);
    dcyc = 8'h80;
    repeat (8) @(negedge clk);
    check("glitch_reject", 32'(duty), 32'h80);
    dcyc = 8'h55;
    repeat (6) @(negedge clk);
    check("glitch_accept", 32'(duty), 32'h55);

    // Enable drop mid-period at cnt=50 with duty 128.
    load_duty(8'd128, "load128");
    check("idle_pwm", 32'(pwm), 32'd0);
    en = 1'b1;
    @(negedge clk);
    check("en_first_hi", 32'(pwm), 32'd1);
    repeat (199) @(negedge clk);
    check("cnt50_pwm", 32'(pwm), 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("endrop_pwm",    32'(pwm),        32'd0);
    check("endrop_cnt",    32'(dut.cnt_q),  32'd0);
    check("endrop_pstart", 32'(pstart),     32'd0);
    en = 1'b1;
    measure(hi, len);
    check("d128_hi",  32'(hi),  32'd512);
    check("d128_len", 32'(len), 32'd1024);

    // Asynchronous reset while PWM_OUT is high.
    repeat (100) @(negedge clk);
    check("prerst_pwm", 32'(pwm), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_pwm",  32'(pwm),  32'd0);
    check("async_duty", 32'(duty), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
